// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, FSM states and datapath select encodings shared by the multicycle MIPS core
package mips_pkg;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, LOGIEX, IMMWB, BRANCH, JUMP, HALT
  } state_t;
  typedef enum logic [2:0] {AND, OR, ADD, SUB, SLT} alu_op_t;
  typedef enum logic [2:0] {SB_B, SB_FOUR, SB_SIMM, SB_SIMM4, SB_ZIMM} srcb_t;
  typedef enum logic [1:0] {PC_ALU, PC_OUT, PC_JMP} pc_src_t;
endpackage

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle FSM and ALU decode driving the datapath selects, enables and memory strobes
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic zero,
  input  logic mem_ready,
  output logic mem_req,
  output logic mem_we,
  output logic iord,
  output logic ir_en,
  output logic pc_en,
  output logic ab_en,
  output logic alu_en,
  output logic mdr_en,
  output logic rf_we,
  output logic rf_dst,
  output logic rf_mem,
  output logic srca,
  output logic halt,
  output srcb_t srcb,
  output alu_op_t alu_op,
  output pc_src_t pc_src
);
  state_t state, state_n;
  logic funct_ok;
  assign funct_ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else state <= state_n;
  always_comb begin
    state_n = state;
    {mem_req, mem_we, iord, ir_en, pc_en, ab_en, alu_en, mdr_en} = '0;
    {rf_we, rf_dst, rf_mem, srca, halt} = '0;
    srcb = SB_B;
    alu_op = ADD;
    pc_src = PC_ALU;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        srcb = SB_FOUR;
        ir_en = mem_ready;
        pc_en = mem_ready;
        state_n = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ab_en = 1'b1;
        alu_en = 1'b1;
        srcb = SB_SIMM4;
        state_n = (op == OP_LW || op == OP_SW) ? MEMADR : op == OP_R ? EXEC :
                  (op == OP_BEQ || op == OP_BNE) ? BRANCH : op == OP_ADDI ? ADDIEX :
                  (op == OP_ANDI || op == OP_ORI) ? LOGIEX : op == OP_J ? JUMP : HALT;
      end
      MEMADR: begin
        srca = 1'b1;
        srcb = SB_SIMM;
        alu_en = 1'b1;
        state_n = op == OP_LW ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord = 1'b1;
        mdr_en = mem_ready;
        state_n = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        rf_we = 1'b1;
        rf_mem = 1'b1;
        state_n = FETCH;
      end
      MEMWR: begin
        mem_req = 1'b1;
        mem_we = 1'b1;
        iord = 1'b1;
        state_n = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        srca = 1'b1;
        alu_op = funct == FN_SUB ? SUB : funct == FN_AND ? AND : funct == FN_OR ? OR :
                 funct == FN_SLT ? SLT : ADD;
        alu_en = funct_ok;
        state_n = funct_ok ? ALUWB : HALT;
      end
      ALUWB: begin
        rf_we = 1'b1;
        rf_dst = 1'b1;
        state_n = FETCH;
      end
      ADDIEX: begin
        srca = 1'b1;
        srcb = SB_SIMM;
        alu_en = 1'b1;
        state_n = IMMWB;
      end
      LOGIEX: begin
        srca = 1'b1;
        srcb = SB_ZIMM;
        alu_op = op == OP_ANDI ? AND : OR;
        alu_en = 1'b1;
        state_n = IMMWB;
      end
      IMMWB: begin
        rf_we = 1'b1;
        state_n = FETCH;
      end
      BRANCH: begin
        // ALUOut keeps the target computed in DECODE; op is beq or bne here
        srca = 1'b1;
        alu_op = SUB;
        pc_src = PC_OUT;
        pc_en = (op == OP_BEQ) == zero;
        state_n = FETCH;
      end
      JUMP: begin
        pc_src = PC_JMP;
        pc_en = 1'b1;
        state_n = FETCH;
      end
      HALT: halt = 1'b1;
      default: state_n = HALT;
    endcase
  end
endmodule

// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS datapath sharing one ALU and one req/ready memory port
module mips_multicycle
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int MEM_AW = 8
) (
  input  logic clk,
  input  logic reset,
  output logic mem_req,
  output logic mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic mem_ready,
  output logic halted
);
  logic [31:0] pc, ir, a, b, alu_out, mdr, simm, src_a, src_b, alu_y, rd1, rd2, wd;
  logic [31:0] rf [32];
  logic [4:0] wa;
  logic req, we, halt, iord, ir_en, pc_en, ab_en, alu_en, mdr_en, rf_we, rf_dst, rf_mem, srca;
  srcb_t srcb;
  alu_op_t alu_op;
  pc_src_t pc_src;
  mips_mc_ctrl u_ctrl (
    .clk(clk), .reset(reset), .op(ir[31:26]), .funct(ir[5:0]), .zero(alu_y == 32'd0),
    .mem_ready(mem_ready), .mem_req(req), .mem_we(we), .iord(iord), .ir_en(ir_en),
    .pc_en(pc_en), .ab_en(ab_en), .alu_en(alu_en), .mdr_en(mdr_en), .rf_we(rf_we),
    .rf_dst(rf_dst), .rf_mem(rf_mem), .srca(srca), .halt(halt), .srcb(srcb),
    .alu_op(alu_op), .pc_src(pc_src)
  );
  assign mem_req = req & !reset;
  assign mem_we = we & !reset;
  assign halted = halt & !reset;
  assign mem_addr = iord ? alu_out[MEM_AW-1:0] : pc[MEM_AW-1:0];
  assign mem_wdata = b;
  assign simm = {{16{ir[15]}}, ir[15:0]};
  assign rd1 = ir[25:21] == 5'd0 ? 32'd0 : rf[ir[25:21]];
  assign rd2 = ir[20:16] == 5'd0 ? 32'd0 : rf[ir[20:16]];
  assign wa = rf_dst ? ir[15:11] : ir[20:16];
  assign wd = rf_mem ? mdr : alu_out;
  assign src_a = srca ? a : pc;
  assign src_b = srcb == SB_FOUR ? 32'd4 : srcb == SB_SIMM ? simm : srcb == SB_SIMM4 ? {simm[29:0], 2'b00} :
                 srcb == SB_ZIMM ? {16'd0, ir[15:0]} : b;
  assign alu_y = alu_op == AND ? src_a & src_b : alu_op == OR ? src_a | src_b :
                 alu_op == SUB ? src_a - src_b : alu_op == SLT ? {31'd0, $signed(src_a) < $signed(src_b)} :
                 src_a + src_b;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= RESET_PC;
      {ir, a, b, alu_out, mdr} <= '0;
    end else begin
      if (pc_en) pc <= pc_src == PC_OUT ? alu_out : pc_src == PC_JMP ? {pc[31:28], ir[25:0], 2'b00} : alu_y;
      if (ir_en) ir <= mem_rdata;
      if (ab_en) {a, b} <= {rd1, rd2};
      if (alu_en) alu_out <= alu_y;
      if (mdr_en) mdr <= mem_rdata;
    end
  // $0 is never stored; reads of index 0 are forced to zero above
  always_ff @(posedge clk)
    if (rf_we && wa != 5'd0) rf[wa] <= wd;
endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: scoreboard bench driving a behavioural memory with optional wait states
module tb_mips_multicycle;
  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
  logic mem_req, mem_we, halted;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [64];
  logic [39:0] exp_q [$];
  logic [40:0] snap = '0;
  logic rand_mode = 1'b0, block_wr = 1'b0, prev_stall = 1'b0;
  int wait_left = -1, vectors = 0, miscompares = 0;

  localparam logic [31:0] TEXTBOOK [18] = '{
    32'h20020005, 32'h2003000c, 32'h2067fff7, 32'h00e22025, 32'h00642824, 32'h00a42820,
    32'h10a7000a, 32'h0064202a, 32'h10800001, 32'h20050000, 32'h00e2202a, 32'h00853820,
    32'h00e23822, 32'hac670044, 32'h8c020050, 32'h08000011, 32'h20020001, 32'hac020054};
  localparam logic [31:0] P2 [14] = '{
    32'h20020005, 32'h2002ffff, 32'h30438000, 32'h3404ffff, 32'h10000002, 32'h20050001, 32'h20050001,
    32'h14640001, 32'h20060001, 32'h10640001, 32'hac030040, 32'hac040044, 32'hac020048, 32'hfc000000};
  localparam int P2_FETCH [9][2] = '{
    '{8, 4}, '{12, 4}, '{16, 4}, '{28, 3}, '{36, 3}, '{40, 3}, '{44, 4}, '{48, 4}, '{52, 4}};
  localparam logic [31:0] P3 [3] = '{32'h20000009, 32'hac00005c, 32'hfc000000};
  localparam logic [31:0] P4 [2] = '{32'h20020003, 32'hac020060};

  mips_multicycle #(.RESET_PC(32'h0), .MEM_AW(8)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .halted(halted));

  assign mem_rdata = mem[mem_addr[7:2]];
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model runs once per falling edge: hold checks, ready choice, write scoreboard
  task automatic step();
    logic [39:0] e;
    @(negedge clk);
    if (prev_stall && mem_req) check("hold", {mem_we, mem_addr, mem_wdata}, snap);
    if (!mem_req) wait_left = -1;
    else if (wait_left < 0) wait_left = rand_mode ? int'($urandom_range(0, 3)) : 0;
    mem_ready = (block_wr && mem_we) ? 1'b0 : (!rand_mode || (mem_req && wait_left == 0));
    if (wait_left > 0) wait_left--;
    prev_stall = mem_req && !mem_ready;
    snap = {mem_we, mem_addr, mem_wdata};
    if (mem_req && mem_ready) begin
      wait_left = -1;
      if (mem_we) begin
        check("write expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("write addr/data", {mem_addr, mem_wdata}, e);
        end
        mem[mem_addr[7:2]] = mem_wdata;
      end
    end
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 32'd0;
  endtask

  task automatic go();
    step();
    reset = 1'b0;
    #1;
    check("first fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h00});
  endtask

  task automatic next_fetch(input logic [7:0] addr, input int gap);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(mem_req && !mem_we && mem_addr == addr) && n < 40);
    check($sformatf("fetch %0h gap", addr), 64'(n), 64'(gap));
  endtask

  task automatic wait_halt(input int max);
    int n = 0;
    while (!halted && n < max) begin
      step();
      n++;
    end
    check("halted", halted, 1);
  endtask

  initial begin
    step();
    check("rst req", mem_req, 0);
    check("rst we", mem_we, 0);
    check("rst halted", halted, 0);
    check("rst pc", dut.pc, 0);
    check("rst ir", dut.ir, 0);
    check("rst aluout", dut.alu_out, 0);
    for (int r = 0; r < 2; r++) begin
      reset = 1'b1;
      rand_mode = (r == 1);
      clear_mem();
      foreach (TEXTBOOK[i]) mem[i] = TEXTBOOK[i];
      exp_q.push_back({8'd80, 32'd7});
      exp_q.push_back({8'd84, 32'd7});
      go();
      wait_halt(1000);
      check("textbook mem80", mem[20], 7);
      check("textbook mem84", mem[21], 7);
      check("textbook drained", exp_q.size(), 0);
    end
    reset = 1'b1;
    rand_mode = 1'b0;
    clear_mem();
    foreach (P2[i]) mem[i] = P2[i];
    exp_q.push_back({8'd64, 32'h0000_8000});
    exp_q.push_back({8'd68, 32'h0000_ffff});
    exp_q.push_back({8'd72, 32'hffff_ffff});
    go();
    step();
    step();
    step();
    check("addi before wb", dut.rf[2], 7);
    step();
    check("addi wb edge4", dut.rf[2], 5);
    check("fetch 4", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h04});
    foreach (P2_FETCH[i]) next_fetch(8'(P2_FETCH[i][0]), P2_FETCH[i][1]);
    step();
    check("p2 not yet halted", halted, 0);
    step();
    check("p2 halted", halted, 1);
    check("p2 halt pc", dut.pc, 32'h38);
    check("andi", dut.rf[3], 32'h0000_8000);
    check("ori", dut.rf[4], 32'h0000_ffff);
    check("p2 drained", exp_q.size(), 0);
    reset = 1'b1;
    clear_mem();
    foreach (P3[i]) mem[i] = P3[i];
    exp_q.push_back({8'd92, 32'd0});
    go();
    next_fetch(8'h04, 4);
    next_fetch(8'h08, 4);
    step();
    check("p3 decode halted", halted, 0);
    step();
    check("p3 halted", halted, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("halt no req", mem_req, 0);
    end
    check("halt pc", dut.pc, 32'h0c);
    check("p3 drained", exp_q.size(), 0);
    reset = 1'b1;
    #1;
    check("reset clears halted", halted, 0);
    clear_mem();
    foreach (P4[i]) mem[i] = P4[i];
    block_wr = 1'b1;
    go();
    for (int k = 0; k < 20 && !mem_we; k++) step();
    check("sw issued", mem_we, 1);
    step();
    step();
    reset = 1'b1;
    #1;
    check("abort req", mem_req, 0);
    check("abort we", mem_we, 0);
    step();
    step();
    check("abort pc", dut.pc, 0);
    check("abort no write", mem[24], 0);
    block_wr = 1'b0;
    exp_q.push_back({8'd96, 32'd3});
    reset = 1'b0;
    #1;
    check("refetch reset pc", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h00});
    wait_halt(100);
    check("p4 mem96", mem[24], 3);
    check("p4 drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
